kf_step_sequencer: RTL and testbench
====================================

// Module: kf_step_sequencer
// PURPOSE
//  Sequences one Kalman-filter iteration per sample tick.
//  Waits for the SPI front-end controller to report the register map configured.
//  Per tick: steps a fixed micro-op table through the shared ALU (start/done handshake),
//  then asks the SPI front-end to ship the result (write_enable/done handshake).
//  Sits between the SPI front-end controller, the register map and the shared ALU.
// PARAMETERS
//  NUM_STEPS    6   micro-ops per iteration; table STEP_TABLE[0:NUM_STEPS-1] lives in kf_pkg
//  ALU_TIMEOUT  64  max cycles in WAIT_ALU before error; counter width $clog2(ALU_TIMEOUT+1)
//  OUT_TIMEOUT  4095 max cycles in WRITE awaiting done_in before error
// PORTS
//  clk              in   1  system clock, rising edge
//  n_rst            in   1  asynchronous active-low reset
//  configured_in    in   1  register map loaded (level, from SPI front-end)
//  sample_tick_in   in   1  1-cycle strobe: new sample period
//  alu_done_in      in   1  1-cycle strobe: ALU result written to dst
//  done_in          in   1  1-cycle strobe: SPI front-end finished output transfer
//  clear_err_in     in   1  clears error_out/overrun_out, ERROR->WAIT_TICK
//  alu_start_out    out  1  1-cycle start pulse
//  alu_op_out       out  3  kf_pkg::alu_op_t of current step
//  alu_src_a_out    out  3  operand A register address
//  alu_src_b_out    out  3  operand B register address
//  alu_dst_out      out  3  destination register address
//  write_enable_out out  1  request output transfer (level)
//  busy_out         out  1  high in ISSUE/WAIT_ALU/WRITE
//  step_out         out  3  current step index
//  error_out        out  1  sticky timeout flag
//  overrun_out      out  1  sticky: tick arrived while busy
// BEHAVIOUR
//  Reset: state UNCONF; step=0; all outputs 0 (alu_* fields drive STEP_TABLE[0] decode, start=0).
//  States: UNCONF, WAIT_TICK, ISSUE, WAIT_ALU, WRITE, ERROR.
//  UNCONF: configured_in=1 -> WAIT_TICK. Ticks ignored, no overrun.
//  WAIT_TICK: sample_tick_in=1 -> ISSUE, step<=0 (tick at edge t, start pulse during cycle t+1).
//  ISSUE: alu_start_out=1 one cycle; -> WAIT_ALU; timeout counter <=0.
//  WAIT_ALU: alu_done_in=1 -> step==NUM_STEPS-1 ? WRITE : (step++, ISSUE).
//   alu_done_in sampled only here; a done in ISSUE is ignored.
//   counter==ALU_TIMEOUT -> ERROR, error_out<=1.
//  alu_op/src/dst outputs: combinational decode of STEP_TABLE[step]; stable ISSUE..WAIT_ALU.
//  WRITE: write_enable_out=1; done_in=1 -> WAIT_TICK (WE low next cycle, so front-end
//   Idle never re-triggers); counter==OUT_TIMEOUT -> ERROR, error_out<=1.
//  ERROR: all strobes/WE low; clear_err_in=1 -> WAIT_TICK.
//  Overrun: sample_tick_in in ISSUE/WAIT_ALU/WRITE/ERROR -> overrun_out<=1; tick dropped,
//   iteration in flight unaffected.
//  clear_err_in clears error_out and overrun_out in any state; set wins if same cycle.
//  configured_in falling outside UNCONF: ignored (config is sticky upstream).
//  Tick and done_in same cycle in WRITE: go WAIT_TICK, tick counts as overrun.
//  Async reset mid-iteration: immediate return to UNCONF, WE and start low, flags cleared.
// STRUCTURE
//  kf_pkg: alu_op_t enum {OP_ADD,OP_SUB,OP_MUL,OP_MAC,OP_DIV}; reg addr consts
//   (ACC=0,GYRO=1,MAG=2,DEC=3,DT=4,ANGLE=5,BIAS=6,PCOV=7); step_t struct {op,a,b,dst};
//   STEP_TABLE constant; seq_state_t enum.
//  Sub-module kf_timeout_ctr (clear, enable, limit, expired) shared by WAIT_ALU and WRITE.
// TESTING
//  Reset, configured_in=0, ticks -> stays UNCONF, no alu_start, overrun_out=0.
//  Configure, tick, ALU done 3 cycles after each start -> 6 start pulses, step_out 0..5,
//   fields match STEP_TABLE, then WE=1 until done_in; WE low cycle after done.
//  Tick during WAIT_ALU step 2 -> overrun_out=1, still 6 ops, one WE request only.
//  Withhold alu_done_in 65 cycles -> ERROR, error_out=1; clear_err_in -> WAIT_TICK, next tick runs.
//  Withhold done_in 4096 cycles in WRITE -> error_out=1, WE drops.
//  n_rst low during step 3 -> UNCONF, all outputs 0; reconfigure + tick -> restarts at step 0.

Source files
------------

// File: rtl/kf_pkg.sv
//==============================================================================
// Module : kf_pkg
// Brief  : Shared types, register addresses and the micro-op table for one
//          Kalman-filter iteration.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package kf_pkg;

    localparam int NUM_STEPS = 6;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_MAC = 3'd3,
        OP_DIV = 3'd4
    } alu_op_t;

    typedef logic [2:0] reg_addr_t;

    localparam reg_addr_t ACC   = 3'd0;
    localparam reg_addr_t GYRO  = 3'd1;
    localparam reg_addr_t MAG   = 3'd2;
    localparam reg_addr_t DEC   = 3'd3;
    localparam reg_addr_t DT    = 3'd4;
    localparam reg_addr_t ANGLE = 3'd5;
    localparam reg_addr_t BIAS  = 3'd6;
    localparam reg_addr_t PCOV  = 3'd7;

    typedef struct packed {
        alu_op_t   op;
        reg_addr_t a;
        reg_addr_t b;
        reg_addr_t dst;
    } step_t;

    // Predict (rate, angle, covariance), then correct with the accelerometer angle.
    localparam step_t STEP_TABLE [NUM_STEPS] = '{
        '{op: OP_SUB, a: GYRO,  b: BIAS,  dst: DEC  },
        '{op: OP_MAC, a: DEC,   b: DT,    dst: ANGLE},
        '{op: OP_MAC, a: PCOV,  b: DT,    dst: PCOV },
        '{op: OP_SUB, a: ACC,   b: ANGLE, dst: DEC  },
        '{op: OP_DIV, a: PCOV,  b: MAG,   dst: MAG  },
        '{op: OP_MAC, a: MAG,   b: DEC,   dst: ANGLE}
    };

    typedef enum logic [2:0] {
        ST_UNCONF    = 3'd0,
        ST_WAIT_TICK = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_ALU  = 3'd3,
        ST_WRITE     = 3'd4,
        ST_ERROR     = 3'd5
    } seq_state_t;

    // Out-of-range indices fall back to the first entry so the decode is total.
    function automatic step_t step_decode(input logic [2:0] idx);
        if (int'(idx) < NUM_STEPS) begin
            return STEP_TABLE[idx];
        end
        return STEP_TABLE[0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/kf_timeout_ctr.sv
//==============================================================================
// Module : kf_timeout_ctr
// Brief  : Saturating wait counter; flags expiry when the count reaches limit.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module kf_timeout_ctr #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign expired = (r_count == limit);

endmodule

`default_nettype wire

// File: rtl/kf_step_sequencer.sv
//==============================================================================
// Module : kf_step_sequencer
// Brief  : Runs one Kalman-filter micro-op sequence through the shared ALU per
//          sample tick, then hands the result to the SPI front-end.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module kf_step_sequencer
    import kf_pkg::*;
#(
    parameter int ALU_TIMEOUT = 64,
    parameter int OUT_TIMEOUT = 4095
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       configured_in,
    input  logic       sample_tick_in,
    input  logic       alu_done_in,
    input  logic       done_in,
    input  logic       clear_err_in,
    output logic       alu_start_out,
    output logic [2:0] alu_op_out,
    output logic [2:0] alu_src_a_out,
    output logic [2:0] alu_src_b_out,
    output logic [2:0] alu_dst_out,
    output logic       write_enable_out,
    output logic       busy_out,
    output logic [2:0] step_out,
    output logic       error_out,
    output logic       overrun_out
);

    localparam int c_ALU_W = $clog2(ALU_TIMEOUT + 1);
    localparam int c_OUT_W = $clog2(OUT_TIMEOUT + 1);
    localparam int c_CTR_W = (c_ALU_W > c_OUT_W) ? c_ALU_W : c_OUT_W;

    seq_state_t         r_state;
    seq_state_t         w_next_state;
    logic [2:0]         r_step;
    logic [2:0]         w_step_next;
    logic               r_error;
    logic               r_overrun;
    logic               w_ctr_clear;
    logic               w_ctr_en;
    logic               w_ctr_expired;
    logic [c_CTR_W-1:0] w_ctr_limit;
    logic               w_timeout_err;
    logic               w_tick_overrun;
    step_t              w_step_fields;

    // One counter serves both waits; it is cleared whenever a wait begins.
    kf_timeout_ctr #(
        .WIDTH (c_CTR_W)
    ) u_timeout_ctr (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear   (w_ctr_clear),
        .enable  (w_ctr_en),
        .limit   (w_ctr_limit),
        .expired (w_ctr_expired)
    );

    assign w_ctr_limit = (r_state == ST_WRITE) ? c_CTR_W'(OUT_TIMEOUT)
                                               : c_CTR_W'(ALU_TIMEOUT);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_UNCONF;
            r_step  <= '0;
        end else begin
            r_state <= w_next_state;
            r_step  <= w_step_next;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_step_next   = r_step;
        w_ctr_clear   = 1'b1;
        w_ctr_en      = 1'b0;
        w_timeout_err = 1'b0;
        case (r_state)
            ST_UNCONF: begin
                if (configured_in) begin
                    w_next_state = ST_WAIT_TICK;
                end
            end
            ST_WAIT_TICK: begin
                if (sample_tick_in) begin
                    w_next_state = ST_ISSUE;
                    w_step_next  = '0;
                end
            end
            ST_ISSUE: begin
                w_next_state = ST_WAIT_ALU;
            end
            ST_WAIT_ALU: begin
                w_ctr_clear = 1'b0;
                w_ctr_en    = 1'b1;
                if (alu_done_in) begin
                    w_ctr_clear = 1'b1;
                    if (r_step == 3'(NUM_STEPS - 1)) begin
                        w_next_state = ST_WRITE;
                    end else begin
                        w_step_next  = r_step + 3'd1;
                        w_next_state = ST_ISSUE;
                    end
                end else if (w_ctr_expired) begin
                    w_next_state  = ST_ERROR;
                    w_timeout_err = 1'b1;
                end
            end
            ST_WRITE: begin
                w_ctr_clear = 1'b0;
                w_ctr_en    = 1'b1;
                if (done_in) begin
                    w_next_state = ST_WAIT_TICK;
                end else if (w_ctr_expired) begin
                    w_next_state  = ST_ERROR;
                    w_timeout_err = 1'b1;
                end
            end
            ST_ERROR: begin
                if (clear_err_in) begin
                    w_next_state = ST_WAIT_TICK;
                end
            end
            default: begin
                w_next_state = ST_UNCONF;
            end
        endcase
    end

    // A tick is only consumed in WAIT_TICK; anywhere past configuration it is an overrun.
    assign w_tick_overrun = sample_tick_in &&
                            ((r_state == ST_ISSUE) || (r_state == ST_WAIT_ALU) ||
                             (r_state == ST_WRITE) || (r_state == ST_ERROR));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_error   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_timeout_err) begin
                r_error <= 1'b1;
            end else if (clear_err_in) begin
                r_error <= 1'b0;
            end
            if (w_tick_overrun) begin
                r_overrun <= 1'b1;
            end else if (clear_err_in) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign w_step_fields    = step_decode(r_step);
    assign alu_op_out       = w_step_fields.op;
    assign alu_src_a_out    = w_step_fields.a;
    assign alu_src_b_out    = w_step_fields.b;
    assign alu_dst_out      = w_step_fields.dst;
    assign alu_start_out    = (r_state == ST_ISSUE);
    assign write_enable_out = (r_state == ST_WRITE);
    assign busy_out         = (r_state == ST_ISSUE) || (r_state == ST_WAIT_ALU) ||
                              (r_state == ST_WRITE);
    assign step_out         = r_step;
    assign error_out        = r_error;
    assign overrun_out      = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_kf_step_sequencer.sv
//==============================================================================
// Module : tb_kf_step_sequencer
// Brief  : Scoreboard bench for kf_step_sequencer with an auto-responding ALU.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_kf_step_sequencer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       configured_in;
    logic       sample_tick_in;
    logic       alu_done_in;
    logic       done_in;
    logic       clear_err_in;
    logic       alu_start_out;
    logic [2:0] alu_op_out;
    logic [2:0] alu_src_a_out;
    logic [2:0] alu_src_b_out;
    logic [2:0] alu_dst_out;
    logic       write_enable_out;
    logic       busy_out;
    logic [2:0] step_out;
    logic       error_out;
    logic       overrun_out;

    kf_step_sequencer dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .configured_in    (configured_in),
        .sample_tick_in   (sample_tick_in),
        .alu_done_in      (alu_done_in),
        .done_in          (done_in),
        .clear_err_in     (clear_err_in),
        .alu_start_out    (alu_start_out),
        .alu_op_out       (alu_op_out),
        .alu_src_a_out    (alu_src_a_out),
        .alu_src_b_out    (alu_src_b_out),
        .alu_dst_out      (alu_dst_out),
        .write_enable_out (write_enable_out),
        .busy_out         (busy_out),
        .step_out         (step_out),
        .error_out        (error_out),
        .overrun_out      (overrun_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int step;
        int op;
        int a;
        int b;
        int dst;
    } exp_t;

    // Expected micro-op table: op SUB=1 MAC=3 DIV=4; regs ACC0 GYRO1 MAG2 DEC3 DT4 ANGLE5 BIAS6 PCOV7
    int exp_op  [6] = '{1, 3, 3, 1, 4, 3};
    int exp_a   [6] = '{1, 3, 7, 0, 7, 2};
    int exp_b   [6] = '{6, 4, 4, 5, 2, 3};
    int exp_dst [6] = '{3, 5, 7, 3, 2, 5};

    exp_t sb[$];
    int   n_vec    = 0;
    int   n_err    = 0;
    int   starts   = 0;
    int   we_rises = 0;
    bit   alu_auto = 1'b1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_step(input int i);
        exp_t e;
        e.step = i;
        e.op   = exp_op[i];
        e.a    = exp_a[i];
        e.b    = exp_b[i];
        e.dst  = exp_dst[i];
        sb.push_back(e);
    endtask

    task automatic push_iteration();
        for (int i = 0; i < 6; i++) push_step(i);
    endtask

    // Start-pulse monitor: pops the scoreboard, and checks fields stay put while waiting.
    initial begin
        exp_t cur;
        bit   cur_valid;
        bit   we_prev;
        cur_valid = 1'b0;
        we_prev   = 1'b0;
        forever begin
            @(negedge clk);
            if (n_rst && alu_start_out) begin
                starts++;
                if (sb.size() == 0) begin
                    chk("start_unexpected", 1, 0);
                end else begin
                    cur       = sb.pop_front();
                    cur_valid = 1'b1;
                    chk("step_idx", int'(step_out),      cur.step);
                    chk("alu_op",   int'(alu_op_out),    cur.op);
                    chk("alu_a",    int'(alu_src_a_out), cur.a);
                    chk("alu_b",    int'(alu_src_b_out), cur.b);
                    chk("alu_dst",  int'(alu_dst_out),   cur.dst);
                end
            end else if (n_rst && busy_out && !write_enable_out && cur_valid) begin
                chk("hold_op",  int'(alu_op_out),  cur.op);
                chk("hold_dst", int'(alu_dst_out), cur.dst);
            end
            if (write_enable_out && !we_prev) we_rises++;
            we_prev = write_enable_out;
        end
    end

    // ALU model: done strobe 3 cycles after each observed start.
    initial begin
        forever begin
            @(negedge clk);
            if (alu_start_out && alu_auto) begin
                repeat (3) @(posedge clk);
                #1 alu_done_in = 1'b1;
                @(posedge clk);
                #1 alu_done_in = 1'b0;
            end
        end
    end

    task automatic pulse_tick();
        @(posedge clk); #1 sample_tick_in = 1'b1;
        @(posedge clk); #1 sample_tick_in = 1'b0;
    endtask

    task automatic pulse_done();
        @(posedge clk); #1 done_in = 1'b1;
        @(posedge clk); #1 done_in = 1'b0;
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1 clear_err_in = 1'b1;
        @(posedge clk); #1 clear_err_in = 1'b0;
    endtask

    task automatic wait_we(input int max_cyc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!write_enable_out && n < max_cyc);
        if (!write_enable_out) chk("we_wait_timeout", 0, 1);
    endtask

    task automatic wait_step(input int s, input int max_cyc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(int'(step_out) == s && busy_out && !alu_start_out) && n < max_cyc);
        if (int'(step_out) != s) chk("step_wait_timeout", int'(step_out), s);
    endtask

    task automatic run_iteration();
        int s0;
        s0 = starts;
        push_iteration();
        pulse_tick();
        wait_we(300);
        chk("iter_starts",   starts - s0, 6);
        chk("iter_sb_empty", sb.size(), 0);
        chk("iter_last_step", int'(step_out), 5);
        repeat (2) begin
            @(negedge clk);
            chk("we_hold", int'(write_enable_out), 1);
        end
        pulse_done();
        @(negedge clk);
        chk("we_drop",   int'(write_enable_out), 0);
        chk("idle_busy", int'(busy_out), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_start"},   int'(alu_start_out), 0);
        chk({tag, "_we"},      int'(write_enable_out), 0);
        chk({tag, "_busy"},    int'(busy_out), 0);
        chk({tag, "_step"},    int'(step_out), 0);
        chk({tag, "_error"},   int'(error_out), 0);
        chk({tag, "_overrun"}, int'(overrun_out), 0);
        chk({tag, "_op"},      int'(alu_op_out), exp_op[0]);
        chk({tag, "_a"},       int'(alu_src_a_out), exp_a[0]);
        chk({tag, "_b"},       int'(alu_src_b_out), exp_b[0]);
        chk({tag, "_dst"},     int'(alu_dst_out), exp_dst[0]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int r0;
        n_rst          = 1'b0;
        configured_in  = 1'b0;
        sample_tick_in = 1'b0;
        alu_done_in    = 1'b0;
        done_in        = 1'b0;
        clear_err_in   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk); #1 n_rst = 1'b1;

        // Unconfigured: ticks ignored, no overrun.
        repeat (3) begin
            pulse_tick();
            repeat (4) @(posedge clk);
        end
        @(negedge clk);
        chk("unconf_busy",    int'(busy_out), 0);
        chk("unconf_overrun", int'(overrun_out), 0);
        chk("unconf_starts",  starts, 0);

        configured_in = 1'b1;
        repeat (2) @(posedge clk);
        run_iteration();
        chk("we_rises_1", we_rises, 1);

        // Overrun during step 2.
        r0 = starts;
        push_iteration();
        pulse_tick();
        wait_step(2, 100);
        pulse_tick();
        @(negedge clk);
        chk("overrun_set", int'(overrun_out), 1);
        wait_we(300);
        chk("overrun_starts", starts - r0, 6);
        pulse_done();
        repeat (20) @(negedge clk);
        chk("overrun_we_rises", we_rises, 2);
        chk("overrun_idle",     int'(busy_out), 0);
        chk("overrun_sticky",   int'(overrun_out), 1);
        pulse_clear();
        @(negedge clk);
        chk("overrun_cleared",  int'(overrun_out), 0);

        // ALU timeout: 65 cycles in WAIT_ALU without done.
        alu_auto = 1'b0;
        push_step(0);
        pulse_tick();
        repeat (64) @(posedge clk);
        @(negedge clk);
        chk("alu_to_early_err",  int'(error_out), 0);
        chk("alu_to_early_busy", int'(busy_out), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("alu_to_err",  int'(error_out), 1);
        chk("alu_to_busy", int'(busy_out), 0);
        chk("alu_to_sb",   sb.size(), 0);
        pulse_clear();
        @(negedge clk);
        chk("alu_to_clear", int'(error_out), 0);
        alu_auto = 1'b1;
        run_iteration();

        // Output timeout: 4096 cycles in WRITE without done.
        push_iteration();
        pulse_tick();
        wait_we(300);
        cyc = 0;
        while (!error_out && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        chk("out_to_cycles", cyc, 4096);
        chk("out_to_err",    int'(error_out), 1);
        chk("out_to_we",     int'(write_enable_out), 0);
        pulse_clear();
        @(negedge clk);
        chk("out_to_clear", int'(error_out), 0);

        // Async reset during step 3, with overrun pending.
        push_iteration();
        pulse_tick();
        wait_step(1, 100);
        pulse_tick();
        wait_step(3, 100);
        chk("pre_rst_overrun", int'(overrun_out), 1);
        #2 n_rst = 1'b0;
        configured_in = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        sb.delete();
        repeat (6) @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("post_rst_unconf", int'(busy_out), 0);
        configured_in = 1'b1;
        repeat (2) @(posedge clk);
        run_iteration();
        chk("final_sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
